// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - RISC-V branch/jump resolution with registered redirect outputs
// One shared 33-bit subtractor provides equality, signed and unsigned less-than.
module branch_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_dat_a,
  input  logic [31:0] i_dat_b,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_opcode,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  output logic        o_branch_en,
  output logic        o_valid_q,
  output logic        o_branch_en_q,
  output logic [31:0] o_target_q,
  output logic        o_misalign_q
);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [32:0] diff;
  logic        eq, lt, ltu;
  logic        taken;
  logic [31:0] base, sum, target;

  logic        valid_q, valid_d;
  logic        branch_en_q, branch_en_d;
  logic [31:0] target_q, target_d;
  logic        misalign_q, misalign_d;

  // Bit 32 of the zero-extended difference is the borrow, i.e. unsigned a < b.
  // Signed less-than uses the sign of a when the operand signs differ, since
  // the difference may have overflowed in that case.
  always_comb begin
    diff = {1'b0, i_dat_a} - {1'b0, i_dat_b};
    eq   = (diff[31:0] == 32'h0);
    ltu  = diff[32];
    lt   = (i_dat_a[31] != i_dat_b[31]) ? i_dat_a[31] : diff[31];
  end

  always_comb begin
    taken = 1'b0;
    case (i_opcode)
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      OP_BRANCH: begin
        case (i_funct3)
          3'b000:  taken = eq;
          3'b001:  taken = !eq;
          3'b100:  taken = lt;
          3'b101:  taken = !lt;
          3'b110:  taken = ltu;
          3'b111:  taken = !ltu;
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    base   = (i_opcode == OP_JALR) ? i_dat_a : i_pc;
    sum    = base + i_imm;
    target = (i_opcode == OP_JALR) ? {sum[31:1], 1'b0} : sum;
  end

  always_comb begin
    valid_d     = i_valid;
    branch_en_d = taken & i_valid;
    target_d    = target;
    misalign_d  = taken & i_valid & (target[1:0] != 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      branch_en_q <= 1'b0;
      target_q    <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      branch_en_q <= branch_en_d;
      target_q    <= target_d;
      misalign_q  <= misalign_d;
    end
  end

  assign o_branch_en   = taken;
  assign o_valid_q     = valid_q;
  assign o_branch_en_q = branch_en_q;
  assign o_target_q    = target_q;
  assign o_misalign_q  = misalign_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit with directed and random stimulus
module tb_branch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_dat_a, i_dat_b, i_pc, i_imm;
  logic [2:0]  i_funct3;
  logic [4:0]  i_opcode;
  logic        o_branch_en, o_valid_q, o_branch_en_q, o_misalign_q;
  logic [31:0] o_target_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        br;
    logic        mis;
    logic [31:0] tgt;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   issue_id = 0;

  branch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_funct3(i_funct3),
    .i_opcode(i_opcode), .i_pc(i_pc), .i_imm(i_imm),
    .o_branch_en(o_branch_en), .o_valid_q(o_valid_q),
    .o_branch_en_q(o_branch_en_q), .o_target_q(o_target_q),
    .o_misalign_q(o_misalign_q)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic ref_taken(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    if (op == 5'b11011 || op == 5'b11001) return 1'b1;
    if (op != 5'b11000) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] pc, input logic [31:0] imm);
    if (op == 5'b11001) return (a + imm) & 32'hffff_fffe;
    return pc + imm;
  endfunction

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, got, want);
    end
  endtask

  // Drive one instruction at the falling edge, check the combinational flag,
  // and queue the registered result expected after the next rising edge.
  task automatic issue(input logic rst, input logic vld, input logic [4:0] op,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    logic t;
    logic [31:0] tg;
    @(negedge i_clk);
    i_rst = rst; i_valid = vld; i_opcode = op; i_funct3 = f3;
    i_dat_a = a; i_dat_b = b; i_pc = pc; i_imm = imm;
    #1;
    t  = ref_taken(op, f3, a, b);
    tg = ref_target(op, a, pc, imm);
    check1($sformatf("branch_en op=%b f3=%b a=%h b=%h", op, f3, a, b), o_branch_en, t);
    e.id  = issue_id++;
    if (rst) begin
      e.v = 0; e.br = 0; e.mis = 0; e.tgt = 32'h0;
    end else begin
      e.v = vld; e.br = t & vld; e.mis = t & vld & (tg[1:0] != 2'b00); e.tgt = tg;
    end
    sb.push_back(e);
  endtask

  always @(posedge i_clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check1($sformatf("valid_q #%0d", e.id), o_valid_q, e.v);
      check1($sformatf("branch_en_q #%0d", e.id), o_branch_en_q, e.br);
      check1($sformatf("misalign_q #%0d", e.id), o_misalign_q, e.mis);
      checks++;
      if (o_target_q !== e.tgt) begin
        errors++;
        $display("FAIL target_q #%0d got %h want %h", e.id, o_target_q, e.tgt);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    i_rst = 1; i_valid = 0; i_opcode = 0; i_funct3 = 0;
    i_dat_a = 0; i_dat_b = 0; i_pc = 0; i_imm = 0;
    // Reset state: instruction present during reset is dropped.
    issue(1, 1, 5'b11011, 3'd0, 0, 0, 32'h100, 32'h6);
    issue(1, 1, 5'b11000, 3'd0, 5, 5, 32'h200, 32'h2);
    // Opcode decode
    issue(0, 1, 5'b11001, 3'd0, 0, 0, 0, 0);
    issue(0, 1, 5'b11111, 3'd0, 0, 0, 0, 0);
    issue(0, 1, 5'b11011, 3'd0, 0, 0, 0, 0);
    issue(0, 1, 5'b00000, 3'd0, 0, 0, 0, 0);
    // BEQ / BNE
    issue(0, 1, 5'b11000, 3'd0, 32'h55aa55aa, 32'h55aa55aa, 32'h1000, 32'h10);
    issue(0, 1, 5'b11000, 3'd0, 32'h55aa55aa, 32'haa55aa55, 32'h1000, 32'h10);
    issue(0, 1, 5'b11000, 3'd1, 32'h55aa55aa, 32'haa55aa55, 32'h1000, 32'h10);
    issue(0, 1, 5'b11000, 3'd1, 32'h55aa55aa, 32'h55aa55aa, 32'h1000, 32'h10);
    // Signed
    issue(0, 1, 5'b11000, 3'd4, 32'hffffffff, 32'h1, 0, 8);
    issue(0, 1, 5'b11000, 3'd4, 32'h55, 32'h55, 0, 8);
    issue(0, 1, 5'b11000, 3'd5, 32'h1, 32'h1, 0, 8);
    issue(0, 1, 5'b11000, 3'd5, 32'hffffffff, 32'h1, 0, 8);
    issue(0, 1, 5'b11000, 3'd4, 32'h80000000, 32'h7fffffff, 0, 8);
    // Unsigned
    issue(0, 1, 5'b11000, 3'd6, 32'h1, 32'hffffffff, 0, 8);
    issue(0, 1, 5'b11000, 3'd6, 32'hffffffff, 32'h1, 0, 8);
    issue(0, 1, 5'b11000, 3'd7, 32'hffffffff, 32'h1, 0, 8);
    issue(0, 1, 5'b11000, 3'd7, 32'h1, 32'hffffffff, 0, 8);
    // Reserved funct3, targets and misalignment
    issue(0, 1, 5'b11000, 3'd2, 32'h7, 32'h7, 0, 8);
    issue(0, 1, 5'b11000, 3'd3, 32'h7, 32'h7, 0, 8);
    issue(0, 1, 5'b11001, 3'd0, 32'h00001003, 0, 32'h40, 32'h4);
    issue(0, 1, 5'b11011, 3'd0, 0, 0, 32'hfffffffc, 32'h8);
    issue(0, 1, 5'b11000, 3'd0, 3, 3, 32'h100, 32'h2);
    // Valid gating and reset priority
    issue(0, 1, 5'b11000, 3'd0, 9, 9, 32'h300, 32'h4);
    issue(0, 0, 5'b11000, 3'd0, 9, 9, 32'h300, 32'h4);
    issue(1, 1, 5'b11000, 3'd0, 9, 9, 32'h300, 32'h6);
    issue(0, 1, 5'b11000, 3'd0, 9, 9, 32'h300, 32'h6);
    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 7))
        0: op = 5'b11011;
        1: op = 5'b11001;
        2: op = 5'($urandom);
        default: op = 5'b11000;
      endcase
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      issue(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), op,
            3'($urandom), a, b, $urandom, $urandom);
    end
    @(negedge i_clk);
    i_valid = 0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge i_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
